tap_ctrl: RTL and testbench

//  IEEE 1149.1 TAP controller and instruction register for the JTAG port, upstream of ir_decode.
//  - Runs the 16-state TAP FSM from TMS.
//  - Shifts, captures and updates the IR; drives ir_o into ir_decode.
//  - Produces the DR strobes dr_shift_o, dr_clock_o and dr_upd_o.
//  - Muxes TDO between the IR and the DR chain selected by ir_decode.

---
 rtl/tap_ctrl_pkg.sv | 30 +++
 rtl/tap_ir_reg.sv | 41 ++++
 rtl/tap_ctrl.sv | 144 ++++++++++++++
 tb/tb_tap_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tap_ctrl_pkg.sv
// Shared TAP definitions: state encoding, IR constants and default sizes.
package tap_ctrl_pkg;

    localparam int ir_width = 8;
    localparam int nr_drs   = 5;

    localparam logic [1:0] IR_CAPTURE = 2'b01;
    localparam logic [7:0] IR_IDCODE  = 8'h04;

    // Encoding follows the customary 1149.1 state numbering.
    typedef enum logic [3:0] {
        EXIT2_DR  = 4'h0,
        EXIT1_DR  = 4'h1,
        SHIFT_DR  = 4'h2,
        PAUSE_DR  = 4'h3,
        SEL_IR    = 4'h4,
        UPDATE_DR = 4'h5,
        CAP_DR    = 4'h6,
        SEL_DR    = 4'h7,
        EXIT2_IR  = 4'h8,
        EXIT1_IR  = 4'h9,
        SHIFT_IR  = 4'hA,
        PAUSE_IR  = 4'hB,
        RTI       = 4'hC,
        UPDATE_IR = 4'hD,
        CAP_IR    = 4'hE,
        TLR       = 4'hF
    } tap_state_e;

endpackage

// File: rtl/tap_ir_reg.sv
// Instruction register: capture/shift stage plus the parallel update stage.
module tap_ir_reg
    import tap_ctrl_pkg::*;
#(
    parameter int              IR_W   = ir_width,
    parameter logic [IR_W-1:0] IR_RST = IR_W'(IR_IDCODE)
) (
    input  logic            tck_i,
    input  logic            trst_ni,
    input  logic            cap,
    input  logic            shift,
    input  logic            upd,
    input  logic            rst_ir,
    input  logic            tdi,
    output logic [IR_W-1:0] sr,
    output logic [IR_W-1:0] ir
);

    // Shift stage: capture pattern, LSB-first shift, hold otherwise.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            sr <= '0;
        end else if (cap) begin
            sr <= IR_W'(IR_CAPTURE);
        end else if (shift) begin
            sr <= {tdi, sr[IR_W-1:1]};
        end
    end

    // Update stage: only UPDATE_IR or entry into TLR may change the instruction.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            ir <= IR_RST;
        end else if (rst_ir) begin
            ir <= IR_RST;
        end else if (upd) begin
            ir <= sr;
        end
    end

endmodule

// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP controller: state machine, IR, DR strobes and TDO mux.
// Optional build macro TAP_STATE_OUT_EN exposes the current state on tap_state_o.
//
// state     | meaning
// TLR       | test-logic reset, IR holds IR_RST
// RTI       | run-test/idle
// SEL_DR    | choose DR path
// CAP_DR    | DR chains capture
// SHIFT_DR  | DR chain shifts, drives TDO
// EXIT1_DR  | leave shift
// PAUSE_DR  | DR shift suspended
// EXIT2_DR  | leave pause
// UPDATE_DR | DR chains latch
// SEL_IR    | choose IR path
// CAP_IR    | IR loads capture pattern
// SHIFT_IR  | IR shifts, drives TDO
// EXIT1_IR  | leave shift
// PAUSE_IR  | IR shift suspended
// EXIT2_IR  | leave pause
// UPDATE_IR | IR shift value becomes the instruction
module tap_ctrl
    import tap_ctrl_pkg::*;
#(
    parameter int              IR_W   = ir_width,
    parameter int              NR_DR  = nr_drs,
    parameter logic [IR_W-1:0] IR_RST = IR_W'(IR_IDCODE)
) (
    input  logic             tck_i,
    input  logic             trst_ni,
    input  logic             tms_i,
    input  logic             tdi_i,
    input  logic [NR_DR-1:0] dr_tdo_i,
    input  logic [NR_DR-1:0] sel_tdo_i,
    output logic [IR_W-1:0]  ir_o,
    output logic             dr_shift_o,
    output logic             dr_clock_o,
    output logic             dr_upd_o,
    output logic             tdo_o,
    output logic             tdo_en_o
`ifdef TAP_STATE_OUT_EN
    ,
    output logic [3:0]       tap_state_o
`endif
);

    tap_state_e      state_q;
    tap_state_e      state_d;
    logic [IR_W-1:0] ir_sr;
    logic            dr_bit;

    // State register.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode from TMS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:       state_d = tms_i ? TLR       : RTI;
            RTI:       state_d = tms_i ? SEL_DR    : RTI;
            SEL_DR:    state_d = tms_i ? SEL_IR    : CAP_DR;
            CAP_DR:    state_d = tms_i ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:  state_d = tms_i ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:  state_d = tms_i ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:  state_d = tms_i ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:  state_d = tms_i ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR: state_d = tms_i ? SEL_DR    : RTI;
            SEL_IR:    state_d = tms_i ? TLR       : CAP_IR;
            CAP_IR:    state_d = tms_i ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:  state_d = tms_i ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:  state_d = tms_i ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:  state_d = tms_i ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:  state_d = tms_i ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR: state_d = tms_i ? SEL_DR    : RTI;
            default:   state_d = TLR;
        endcase
    end

    // Moore DR strobes straight from the current state.
    always_comb begin
        dr_shift_o = 1'b0;
        dr_clock_o = 1'b0;
        dr_upd_o   = 1'b0;
        case (state_q)
            CAP_DR:    dr_clock_o = 1'b1;
            SHIFT_DR:  begin
                dr_shift_o = 1'b1;
                dr_clock_o = 1'b1;
            end
            UPDATE_DR: dr_upd_o = 1'b1;
            default:   ;
        endcase
    end

    tap_ir_reg #(
        .IR_W   (IR_W),
        .IR_RST (IR_RST)
    ) u_ir (
        .tck_i   (tck_i),
        .trst_ni (trst_ni),
        .cap     (state_q == CAP_IR),
        .shift   (state_q == SHIFT_IR),
        .upd     (state_q == UPDATE_IR),
        .rst_ir  (state_d == TLR),
        .tdi     (tdi_i),
        .sr      (ir_sr),
        .ir      (ir_o)
    );

    // Selected DR serial output; out-of-range selects fall back to bypass.
    always_comb begin
        dr_bit = dr_tdo_i[0];
        for (int i = 0; i < NR_DR; i++) begin
            if (sel_tdo_i == NR_DR'(i)) begin
                dr_bit = dr_tdo_i[i];
            end
        end
    end

    // TDO launched on the falling edge so it is stable at the next rising edge.
    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            tdo_o    <= 1'b0;
            tdo_en_o <= 1'b0;
        end else begin
            if (state_q == SHIFT_IR) begin
                tdo_o <= ir_sr[0];
            end else if (state_q == SHIFT_DR) begin
                tdo_o <= dr_bit;
            end
            tdo_en_o <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
        end
    end

`ifdef TAP_STATE_OUT_EN
    assign tap_state_o = state_q;
`endif

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed bench for tap_ctrl.
module tb_tap_ctrl;

    localparam logic [3:0] S_TLR      = 4'hF;
    localparam logic [3:0] S_RTI      = 4'hC;
    localparam logic [3:0] S_SEL_IR   = 4'h4;
    localparam logic [3:0] S_SHIFT_DR = 4'h2;
    localparam logic [3:0] S_SHIFT_IR = 4'hA;
    localparam logic [3:0] S_EXIT1_IR = 4'h9;
    localparam logic [3:0] S_PAUSE_IR = 4'hB;
    localparam logic [3:0] S_UPD_IR   = 4'hD;

    logic       tck_i = 1'b0;
    logic       trst_ni;
    logic       tms_i;
    logic       tdi_i;
    logic [4:0] dr_tdo_i;
    logic [4:0] sel_tdo_i;
    logic [7:0] ir_o;
    logic       dr_shift_o;
    logic       dr_clock_o;
    logic       dr_upd_o;
    logic       tdo_o;
    logic       tdo_en_o;
`ifdef TAP_STATE_OUT_EN
    logic [3:0] tap_state_o;
`endif

    int checks   = 0;
    int failures = 0;
    int n_clk, n_shift, n_upd;
    logic [3:0] st;

    tap_ctrl dut (
        .tck_i      (tck_i),
        .trst_ni    (trst_ni),
        .tms_i      (tms_i),
        .tdi_i      (tdi_i),
        .dr_tdo_i   (dr_tdo_i),
        .sel_tdo_i  (sel_tdo_i),
        .ir_o       (ir_o),
        .dr_shift_o (dr_shift_o),
        .dr_clock_o (dr_clock_o),
        .dr_upd_o   (dr_upd_o),
        .tdo_o      (tdo_o),
        .tdo_en_o   (tdo_en_o)
`ifdef TAP_STATE_OUT_EN
        ,
        .tap_state_o(tap_state_o)
`endif
    );

    assign st = dut.state_q;

    always #5 tck_i = ~tck_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One TCK: inputs applied, rising edge, then past the falling edge so TDO is settled.
    task automatic step(input logic tms, input logic tdi);
        tms_i = tms;
        tdi_i = tdi;
        @(posedge tck_i);
        #1;
        n_clk   += int'(dr_clock_o);
        n_shift += int'(dr_shift_o);
        n_upd   += int'(dr_upd_o);
        @(negedge tck_i);
        #1;
    endtask

    task automatic enter_shift_ir();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    logic [7:0]  val;
    logic [31:0] pat;
    logic [4:0]  sels [2];

    initial begin
        trst_ni   = 1'b0;
        tms_i     = 1'b1;
        tdi_i     = 1'b0;
        dr_tdo_i  = '0;
        sel_tdo_i = '0;
        n_clk = 0; n_shift = 0; n_upd = 0;

        // 1: reset state
        @(negedge tck_i);
        #1;
        chk("rst_state", 32'(st), 32'(S_TLR));
        chk("rst_ir", 32'(ir_o), 32'h04);
        chk("rst_tdo_en", 32'(tdo_en_o), 32'h0);
        chk("rst_strobes", 32'({dr_shift_o, dr_clock_o, dr_upd_o}), 32'h0);
`ifdef TAP_STATE_OUT_EN
        chk("rst_tap_state_o", 32'(tap_state_o), 32'(S_TLR));
`endif
        trst_ni = 1'b1;

        // 3: IR scan of 0x81
        step(1'b0, 1'b0);
        chk("ir_rti", 32'(st), 32'(S_RTI));
        enter_shift_ir();
        chk("ir_shift_state", 32'(st), 32'(S_SHIFT_IR));
        chk("ir_tdo_en", 32'(tdo_en_o), 32'h1);
        val = 8'h81;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ir_tdo_bit%0d", i), 32'(tdo_o), (i == 0) ? 32'h1 : 32'h0);
            step(i == 7, val[i]);
        end
        chk("ir_exit1", 32'(st), 32'(S_EXIT1_IR));
        chk("ir_exit1_tdo_en", 32'(tdo_en_o), 32'h0);
        chk("ir_no_early_upd", 32'(ir_o), 32'h04);
        step(1'b1, 1'b0);
        chk("ir_upd_state", 32'(st), 32'(S_UPD_IR));
        step(1'b0, 1'b0);
        chk("ir_0x81", 32'(ir_o), 32'h81);

        // 4: 32-bit DR scan on chain 1
        sel_tdo_i = 5'd1;
        pat = 32'hC5A3_1E96;
        n_clk = 0; n_shift = 0; n_upd = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 0; k < 32; k++) begin
            dr_tdo_i = {2'b00, ~pat[k], pat[k], ~pat[k]};
            step(1'b0, 1'b0);
            chk($sformatf("dr_tdo_%0d", k), 32'(tdo_o), 32'(pat[k]));
        end
        step(1'b1, 1'b0);
        chk("dr_exit_tdo_hold", 32'(tdo_o), 32'(pat[31]));
        chk("dr_exit_tdo_en", 32'(tdo_en_o), 32'h0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("dr_clock_cnt", 32'(n_clk), 32'd33);
        chk("dr_shift_cnt", 32'(n_shift), 32'd32);
        chk("dr_upd_cnt", 32'(n_upd), 32'd1);
        chk("dr_back_rti", 32'(st), 32'(S_RTI));

        // out-of-range selects fall back to chain 0
        sels[0] = 5'd5;
        sels[1] = 5'd7;
        for (int s = 0; s < 2; s++) begin
            sel_tdo_i = sels[s];
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                dr_tdo_i = {2'b00, ~pat[k+s], ~pat[k+s], pat[k+s]};
                step(1'b0, 1'b0);
                chk($sformatf("byp_sel%0d_%0d", sels[s], k), 32'(tdo_o), 32'(pat[k+s]));
            end
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end

        // 2: TMS=1 x5 from SHIFT_DR
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t2_shift_dr", 32'(st), 32'(S_SHIFT_DR));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("t2_after4", 32'(st), 32'(S_SEL_IR));
        chk("t2_ir_kept", 32'(ir_o), 32'h81);
        step(1'b1, 1'b0);
        chk("t2_tlr", 32'(st), 32'(S_TLR));
        chk("t2_ir_reset", 32'(ir_o), 32'h04);

        // 5: IR scan of 0xA6 with a 3-cycle pause after 4 bits
        step(1'b0, 1'b0);
        enter_shift_ir();
        val = 8'hA6;
        for (int i = 0; i < 4; i++) step(i == 3, val[i]);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t5_pause", 32'(st), 32'(S_PAUSE_IR));
        chk("t5_ir_held", 32'(ir_o), 32'h04);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("t5_resume", 32'(st), 32'(S_SHIFT_IR));
        for (int i = 4; i < 8; i++) step(i == 7, val[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("t5_ir_0xA6", 32'(ir_o), 32'hA6);

        // 6: reset mid IR scan
        enter_shift_ir();
        val = 8'h5B;
        for (int i = 0; i < 4; i++) step(1'b0, val[i]);
        chk("t6_in_shift", 32'(st), 32'(S_SHIFT_IR));
        #1;
        trst_ni = 1'b0;
        #1;
        chk("t6_ir", 32'(ir_o), 32'h04);
        chk("t6_state", 32'(st), 32'(S_TLR));
        chk("t6_tdo_en", 32'(tdo_en_o), 32'h0);
        chk("t6_tdo", 32'(tdo_o), 32'h0);
        @(negedge tck_i);
        #1;
        trst_ni = 1'b1;
        step(1'b1, 1'b0);
        chk("t6_stay_tlr", 32'(st), 32'(S_TLR));
        chk("t6_ir_after", 32'(ir_o), 32'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
